// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: funct codes, FSM states, size defaults.
// The ALU decoder reuses the funct encodings.
package muldiv_seq_pkg;

  localparam int unsigned WidthDef = 32;
  localparam int unsigned CntWDef  = 6;

  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} muldiv_state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FunctMult) || (funct == FunctMultu) ||
           (funct == FunctDiv)  || (funct == FunctDivu);
  endfunction

  function automatic logic is_div(input logic [5:0] funct);
    return (funct == FunctDiv) || (funct == FunctDivu);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FunctMult) || (funct == FunctDiv);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath with combinational sign fixup of the
// result; sequencing comes from the load/step strobes.
module muldiv_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, diff, sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remv;

  // Negating the most negative value yields its own bit pattern, which is the
  // correct magnitude when read as unsigned.
  assign a_neg = is_signed_i & src_a_i[WIDTH-1];
  assign b_neg = is_signed_i & src_b_i[WIDTH-1];
  assign a_mag = a_neg ? -src_a_i : src_a_i;
  assign b_mag = b_neg ? -src_b_i : src_b_i;

  // Remainder stays below the divisor, so only the trial difference needs WIDTH+1 bits.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    if (load_i) begin
      div_d = is_div_i;
      if (is_div_i && (src_b_i == '0)) begin
        acc_d     = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        rem_d     = src_a_i;
        opb_d     = '0;
        neg_d     = 1'b0;
        rem_neg_d = 1'b0;
      end else begin
        acc_d     = {{WIDTH{1'b0}}, (is_div_i ? a_mag : b_mag)};
        rem_d     = '0;
        opb_d     = is_div_i ? b_mag : a_mag;
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = a_neg;
      end
    end else if (step_i) begin
      if (div_q) begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remv = rem_neg_q ? -rem_q : rem_q;

  assign hi_o = div_q ? remv : prod[2*WIDTH-1:WIDTH];
  assign lo_o = div_q ? quot : prod[WIDTH-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mul/div sequencer owning HI/LO: FSM, iteration counter, move-to/from handling,
// pipeline stall and flush.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDef,
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic             HiLoRead,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             load, step;
  logic [WIDTH-1:0] dp_hi, dp_lo;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .is_div_i   (is_div(Funct)),
    .is_signed_i(is_signed_op(Funct)),
    .src_a_i    (SrcA),
    .src_b_i    (SrcB),
    .hi_o       (dp_hi),
    .lo_o       (dp_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Flush) begin
          state_d = StIdle;
        end else if (Start && is_muldiv(Funct)) begin
          load    = 1'b1;
          cnt_d   = '0;
          // Divide by zero skips the loop; the datapath preloads the fixed result.
          state_d = (is_div(Funct) && (SrcB == '0)) ? StFix : StCalc;
        end else begin
          if (MtHi) hi_d = SrcA;
          if (MtLo) lo_d = SrcA;
        end
      end
      StCalc: begin
        if (Flush) begin
          state_d = StIdle;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (!Flush) begin
          hi_d = dp_hi;
          lo_d = dp_lo;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy  = (state_q != StIdle);
  assign Stall = Busy & (Start | HiLoRead | MtHi | MtLo);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: ops push expected HI/LO, a monitor pops on Busy falling.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  Funct = 6'b0;
  logic [31:0] SrcA = 32'b0;
  logic [31:0] SrcB = 32'b0;
  logic        MtHi = 1'b0;
  logic        MtLo = 1'b0;
  logic        HiLoRead = 1'b0;
  logic        Flush = 1'b0;
  logic        Stall, Busy;
  logic [31:0] Hi, Lo;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = 32'b0;
  logic [31:0] lo_m = 32'b0;
  bit          busy_seen = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .Funct   (Funct),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .MtHi    (MtHi),
    .MtLo    (MtLo),
    .HiLoRead(HiLoRead),
    .Flush   (Flush),
    .Stall   (Stall),
    .Busy    (Busy),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (f)
      FunctMultu: return {32'b0, a} * {32'b0, b};
      FunctMult:  return 64'(sa * sbv);
      FunctDivu:  return (b == 32'b0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      FunctDiv: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && busy_seen && !Busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got busy fall expected none");
        end else begin
          e = sb.pop_front();
          check("hilo_result", {Hi, Lo}, e);
        end
      end
      busy_seen = Busy;
    end
  end

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int rst_at, input int mt_at);
    logic [63:0] r;
    int          n;
    int          exp_n;
    logic        exp_stall;
    r     = ref_op(f, a, b);
    exp_n = ((f == FunctDiv || f == FunctDivu) && b == 32'b0) ? 1 : 33;
    if (flush_at != 0) sb.push_back({hi_m, lo_m});
    else if (rst_at == 0) sb.push_back(r);
    @(posedge clk); #1;
    Start = 1'b1; Funct = f; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout: got %0d cycles expected %0d", n, exp_n);
        break;
      end
      exp_stall = HiLoRead | MtLo | MtHi | Start;
      check("stall", 64'(Stall), 64'(exp_stall));
      Start = 1'b0; MtLo = 1'b0;
      if (rst_at == n) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_hilo", {Hi, Lo}, 64'b0);
        check("rst_busy", 64'(Busy), 64'b0);
        check("rst_stall", 64'(Stall), 64'b0);
        hi_m = 32'b0; lo_m = 32'b0;
        sb.delete();
        HiLoRead = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (flush_at == n) Flush = 1'b1;
      if (mt_at == n) begin
        MtLo = 1'b1; Start = 1'b1; Funct = FunctMult; SrcA = $urandom;
      end
      HiLoRead = 1'($urandom_range(0, 1));
    end
    HiLoRead = 1'b0; MtLo = 1'b0; Start = 1'b0; Flush = 1'b0;
    check("busy_cycles", 64'(n), 64'((flush_at != 0) ? flush_at : exp_n));
    if (flush_at == 0) begin
      hi_m = r[63:32];
      lo_m = r[31:0];
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'b0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  fns[4];
    logic [31:0] v;
    fns = '{FunctMult, FunctMultu, FunctDiv, FunctDivu};
    HiLoRead = 1'b1;
    #1;
    check("reset_hilo", {Hi, Lo}, 64'b0);
    check("reset_busy", 64'(Busy), 64'b0);
    check("reset_stall", 64'(Stall), 64'b0);
    HiLoRead = 1'b0;
    #21 rst_n = 1'b1;

    run_op(FunctMultu, 32'd7, 32'd6, 0, 0, 0);
    run_op(FunctMult, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    run_op(FunctMult, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    run_op(FunctDiv, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(FunctDivu, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(FunctDivu, 32'd5, 32'd0, 0, 0, 0);

    // MTHI in idle writes at the next edge without stalling.
    @(posedge clk); #1;
    MtHi = 1'b1; SrcA = 32'h1234;
    @(negedge clk);
    check("mthi_stall", 64'(Stall), 64'b0);
    @(posedge clk); #1;
    MtHi = 1'b0;
    hi_m = 32'h1234;
    @(negedge clk);
    check("mthi_hi", {Hi, Lo}, {hi_m, lo_m});

    run_op(FunctMultu, 32'hDEAD_BEEF, 32'h1357_9BDF, 0, 0, 5);
    run_op(FunctMult, 32'h1234_5678, 32'h8765_4321, 10, 0, 0);

    // Unknown funct is ignored.
    @(posedge clk); #1;
    Start = 1'b1; Funct = 6'b100000; SrcA = 32'h5; SrcB = 32'h7;
    @(posedge clk); #1;
    Start = 1'b0;
    @(negedge clk);
    check("bad_funct_busy", 64'(Busy), 64'b0);

    // Flush in idle beats both Start and MTLO.
    @(posedge clk); #1;
    Start = 1'b1; Funct = FunctMult; Flush = 1'b1; MtLo = 1'b1; SrcA = 32'hCAFE_F00D;
    SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0; MtLo = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 64'(Busy), 64'b0);
    check("idle_flush_hilo", {Hi, Lo}, {hi_m, lo_m});

    run_op(FunctDiv, 32'h8765_4321, 32'h0000_1234, 0, 20, 0);

    for (int i = 0; i < 40; i++) begin
      v = pick();
      run_op(fns[$urandom_range(0, 3)], v, pick(), 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
